// File: rtl/spi_adc_ctrl.sv
// SPI master reading 16-bit ADC frames; CPU one-shot and periodic auto requests share the port.
// Latency: grant to first HOLD cycle = CS_SETUP + 2*CLK_DIV*FRAME_BITS; no backpressure, requests collapse.
// Optional SPI_ADC_AVG_EN: sample_o becomes a 4-tap moving average of the extracted field.
module spi_adc_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_MSB   = 12,
  parameter int DATA_LSB   = 5,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int PERIOD     = 1000
) (
  input  logic                  mips_clk,
  input  logic                  mips_rst,
  input  logic                  cpu_req_i,
  input  logic                  auto_en_i,
  output logic                  busy_o,
  output logic                  cpu_done_o,
  output logic                  sample_valid_o,
  output logic [7:0]            sample_o,
  output logic [FRAME_BITS-1:0] frame_o,
  input  logic                  sdo_i,
  output logic                  sck_o,
  output logic                  cs_o
);

  localparam int SW     = DATA_MSB - DATA_LSB + 1;
  localparam int CNT_W  = 16;
  localparam int HALF_W = $clog2(2 * FRAME_BITS);
  localparam int TMR_W  = $clog2(PERIOD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [HALF_W-1:0]     r_half;
  logic [HALF_W-1:0]     w_half_nxt;
  logic                  r_cs;
  logic                  r_sck;
  logic                  w_cs_nxt;
  logic                  w_sck_nxt;
  logic                  w_grant;
  logic                  w_shift_en;
  logic                  w_frame_done;

  logic                  r_cpu_pend;
  logic                  r_auto_pend;
  logic                  r_owner_cpu;
  logic [TMR_W-1:0]      r_timer;
  logic                  w_tick;

  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] r_frame;
  logic [SW-1:0]         r_sample;
  logic [SW-1:0]         w_raw;
  logic                  r_valid;
  logic                  r_done;

  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
      r_cs    <= 1'b1;
      r_sck   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_half  <= w_half_nxt;
      r_cs    <= w_cs_nxt;
      r_sck   <= w_sck_nxt;
    end
  end

  // SHIFT spends 2*FRAME_BITS half-periods; the final half is high, so the
  // last rise (capturing bit 0) lands one half-period before HOLD.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_half_nxt   = r_half;
    w_cs_nxt     = r_cs;
    w_sck_nxt    = r_sck;
    w_grant      = 1'b0;
    w_shift_en   = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_cs_nxt  = 1'b1;
        w_sck_nxt = 1'b1;
        if (r_cpu_pend || r_auto_pend) begin
          w_grant     = 1'b1;
          w_state_nxt = S_SETUP;
          w_cs_nxt    = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_half_nxt  = '0;
          w_sck_nxt   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
          w_cnt_nxt  = '0;
          w_half_nxt = r_half + HALF_W'(1);
          if (r_half == HALF_W'(2 * FRAME_BITS - 1)) begin
            w_state_nxt  = S_HOLD;
            w_cs_nxt     = 1'b1;
            w_frame_done = 1'b1;
          end else begin
            w_sck_nxt  = ~r_sck;
            w_shift_en = ~r_sck;
          end
        end
      end
      S_HOLD: begin
        w_cs_nxt  = 1'b1;
        w_sck_nxt = 1'b1;
        if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_tick = auto_en_i && (r_timer == TMR_W'(PERIOD - 1));

  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      r_timer <= '0;
    end else if (!auto_en_i || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // A new request wins over a grant clearing the same flag.
  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      r_cpu_pend  <= 1'b0;
      r_auto_pend <= 1'b0;
      r_owner_cpu <= 1'b0;
    end else begin
      if (cpu_req_i) begin
        r_cpu_pend <= 1'b1;
      end else if (w_grant && r_cpu_pend) begin
        r_cpu_pend <= 1'b0;
      end
      if (w_tick) begin
        r_auto_pend <= 1'b1;
      end else if (!auto_en_i) begin
        r_auto_pend <= 1'b0;
      end else if (w_grant && !r_cpu_pend) begin
        r_auto_pend <= 1'b0;
      end
      if (w_grant) begin
        r_owner_cpu <= r_cpu_pend;
      end
    end
  end

  assign w_raw = r_shift[DATA_MSB:DATA_LSB];

  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      r_shift <= '0;
      r_frame <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], sdo_i};
      end
      if (w_frame_done) begin
        r_frame <= r_shift;
      end
      r_valid <= w_frame_done;
      r_done  <= w_frame_done && r_owner_cpu;
    end
  end

`ifdef SPI_ADC_AVG_EN
  logic [SW-1:0] r_win [4];
  logic [1:0]    r_wptr;
  logic [SW+1:0] r_sum;
  logic [SW+1:0] w_sum_nxt;

  // The oldest entry is always part of the sum, so the subtraction never wraps.
  assign w_sum_nxt = r_sum + {2'b00, w_raw} - {2'b00, r_win[r_wptr]};

  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
      r_wptr   <= '0;
      r_sum    <= '0;
      r_sample <= '0;
    end else if (w_frame_done) begin
      r_win[r_wptr] <= w_raw;
      r_wptr        <= r_wptr + 2'd1;
      r_sum         <= w_sum_nxt;
      r_sample      <= w_sum_nxt[SW+1:2];
    end
  end
`else
  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      r_sample <= '0;
    end else if (w_frame_done) begin
      r_sample <= w_raw;
    end
  end
`endif

  assign busy_o         = (r_state != S_IDLE);
  assign cpu_done_o     = r_done;
  assign sample_valid_o = r_valid;
  assign sample_o       = r_sample;
  assign frame_o        = r_frame;
  assign sck_o          = r_sck;
  assign cs_o           = r_cs;

endmodule

// File: tb/tb_spi_adc_ctrl.sv
// Bench for spi_adc_ctrl: random ADC frames scored against a queue-based model of the sample rules.
// Covers reset, latency, CPU/auto arbitration, request collapsing, mid-frame reset and averaging.
module tb_spi_adc_ctrl;
  localparam int CLK_DIV    = 4;
  localparam int FRAME_BITS = 16;
  localparam int DATA_MSB   = 12;
  localparam int DATA_LSB   = 5;
  localparam int CS_SETUP   = 2;
  localparam int CS_HOLD    = 2;
  localparam int PERIOD     = 200;

  logic        mips_clk  = 1'b0;
  logic        mips_rst  = 1'b0;
  logic        cpu_req_i = 1'b0;
  logic        auto_en_i = 1'b0;
  logic        sdo_i     = 1'b0;
  logic        busy_o;
  logic        cpu_done_o;
  logic        sample_valid_o;
  logic [7:0]  sample_o;
  logic [15:0] frame_o;
  logic        sck_o;
  logic        cs_o;

  always #5 mips_clk = ~mips_clk;

  spi_adc_ctrl #(
    .CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS), .DATA_MSB(DATA_MSB), .DATA_LSB(DATA_LSB),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .PERIOD(PERIOD)
  ) dut (
    .mips_clk(mips_clk), .mips_rst(mips_rst), .cpu_req_i(cpu_req_i), .auto_en_i(auto_en_i),
    .busy_o(busy_o), .cpu_done_o(cpu_done_o), .sample_valid_o(sample_valid_o),
    .sample_o(sample_o), .frame_o(frame_o), .sdo_i(sdo_i), .sck_o(sck_o), .cs_o(cs_o)
  );

  int checks   = 0;
  int failures = 0;

  // ADC: picks a word when cs falls, presents the next bit on every sck fall.
  logic [15:0] cur_word   = '0;
  logic [15:0] fixed_word = '0;
  logic        fixed_en   = 1'b0;
  int          bit_idx    = 0;

  always @(negedge cs_o) begin
    cur_word = fixed_en ? fixed_word : 16'($urandom);
    bit_idx  = 15;
  end

  always @(negedge sck_o) begin
    if (cs_o === 1'b0 && bit_idx >= 0) begin
      sdo_i   = cur_word[bit_idx];
      bit_idx = bit_idx - 1;
    end
  end

  // Observation side: pulse counters, cs-low run length and a record per completed frame.
  int          valid_cnt   = 0;
  int          done_cnt    = 0;
  int          cs_run      = 0;
  int          last_cs_run = 0;
  logic [15:0] rec_frame[$];
  logic [15:0] rec_word[$];
  logic [7:0]  rec_sample[$];
  logic        rec_done[$];

  always @(negedge mips_clk) begin
    if (cs_o === 1'b0) begin
      cs_run = cs_run + 1;
    end else if (cs_run != 0) begin
      last_cs_run = cs_run;
      cs_run      = 0;
    end
    if (sample_valid_o === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      rec_frame.push_back(frame_o);
      rec_word.push_back(cur_word);
      rec_sample.push_back(sample_o);
      rec_done.push_back(cpu_done_o);
    end
    if (cpu_done_o === 1'b1) done_cnt = done_cnt + 1;
  end

  // Reference: extracted field, optionally averaged over the last four (zero-filled after reset).
  logic [7:0] hist[$];

  function automatic logic [7:0] model_sample(input logic [15:0] w);
    logic [7:0] raw;
    int         sum;
    raw = 8'((w >> DATA_LSB) & 16'h00FF);
    hist.push_back(raw);
    sum = 0;
`ifdef SPI_ADC_AVG_EN
    for (int i = 0; i < 4; i++) if (hist.size() > i) sum = sum + int'(hist[hist.size() - 1 - i]);
    return 8'(sum / 4);
`else
    sum = int'(raw);
    return 8'(sum);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge mips_clk);
    #1;
  endtask

  task automatic pulse_req();
    cpu_req_i = 1'b1;
    step();
    cpu_req_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (sample_valid_o !== 1'b1 && cyc < bound) begin
      step();
      cyc = cyc + 1;
    end
    chk(tag, sample_valid_o, 1);
  endtask

  task automatic wait_busy_rise(input string tag, input int bound, output int cyc);
    logic prev;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    prev = busy_o;
    while (!seen && cyc < bound) begin
      step();
      cyc  = cyc + 1;
      seen = (prev === 1'b0) && (busy_o === 1'b1);
      prev = busy_o;
    end
    chk(tag, seen, 1);
  endtask

  task automatic check_rec(input string tag, input logic exp_done);
    logic [15:0] f;
    logic [15:0] w;
    logic [7:0]  s;
    logic [7:0]  es;
    logic        d;
    chk({tag, "_present"}, rec_frame.size() > 0, 1);
    if (rec_frame.size() == 0) return;
    f  = rec_frame.pop_front();
    w  = rec_word.pop_front();
    s  = rec_sample.pop_front();
    d  = rec_done.pop_front();
    es = model_sample(w);
    chk({tag, "_frame"}, f, w);
    chk({tag, "_sample"}, s, es);
    chk({tag, "_done"}, d, exp_done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the sequence finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int v0;
    int d0;
    logic [1:0] pat [5];
    logic [7:0] avg_raw [4];
    logic [7:0] avg_exp [4];

    // Reset state
    mips_rst = 1'b0;
    repeat (3) step();
    chk("rst_cs", cs_o, 1);
    chk("rst_sck", sck_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", cpu_done_o, 0);
    chk("rst_valid", sample_valid_o, 0);
    chk("rst_sample", sample_o, 0);
    chk("rst_frame", frame_o, 0);
    mips_rst = 1'b1;
    step();

    // Directed 16'h1EE0 frame: latency, extraction, single pulses, cs width
    fixed_en   = 1'b1;
    fixed_word = 16'h1EE0;
    v0 = valid_cnt;
    d0 = done_cnt;
    pulse_req();
    wait_valid("lat_wait", 300, cyc);
    chk("latency", cyc, 131);
    chk("frame_1ee0", frame_o, 16'h1EE0);
`ifndef SPI_ADC_AVG_EN
    chk("sample_f7", sample_o, 8'hF7);
`endif
    chk("done_pulse", cpu_done_o, 1);
    repeat (20) step();
    chk("valid_once", valid_cnt - v0, 1);
    chk("done_once", done_cnt - d0, 1);
    chk("cs_low_len", last_cs_run, 130);
    check_rec("directed", 1'b1);
    fixed_en = 1'b0;

    // Random CPU frames
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 20)) step();
      pulse_req();
      wait_valid("rand_wait", 300, cyc);
      chk("rand_latency", cyc, 131);
      repeat (3) step();
      check_rec("rand", 1'b1);
    end

    // Three requests while busy collapse into one extra frame
    v0 = valid_cnt;
    pulse_req();
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      repeat ($urandom_range(1, 20)) step();
    end
    repeat (400) step();
    chk("collapse_cnt", valid_cnt - v0, 2);
    check_rec("collapse_a", 1'b1);
    check_rec("collapse_b", 1'b1);
    chk("collapse_idle", busy_o, 0);

    // Auto sampling every PERIOD cycles, then a CPU request on the same cycle as a tick
    d0 = done_cnt;
    auto_en_i = 1'b1;
    wait_busy_rise("auto_first", 400, cyc);
    wait_busy_rise("auto_second", 400, cyc);
    chk("auto_period_a", cyc, PERIOD);
    wait_busy_rise("auto_third", 400, cyc);
    chk("auto_period_b", cyc, PERIOD);
    repeat (PERIOD - 2) step();
    pulse_req();
    wait_valid("simul_wait", 300, cyc);
    chk("simul_latency", cyc, 131);
    chk("simul_cpu_first", cpu_done_o, 1);
    repeat (2) step();
    chk("simul_gap", busy_o, 0);
    step();
    chk("simul_auto_follow", busy_o, 1);
    auto_en_i = 1'b0;
    wait_valid("follow_wait", 300, cyc);
    chk("follow_auto_done", cpu_done_o, 0);
    repeat (5) step();
    chk("follow_idle", busy_o, 0);
    pat = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    for (int i = 0; i < 5; i++) check_rec("auto_seq", pat[i][0]);
    chk("auto_done_cnt", done_cnt - d0, 1);

    // Reset in the middle of SHIFT
    v0 = valid_cnt;
    pulse_req();
    repeat (65) step();
    chk("mid_cs_low", cs_o, 0);
    #2 mips_rst = 1'b0;
    #1;
    chk("abort_cs", cs_o, 1);
    chk("abort_sck", sck_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_frame", frame_o, 0);
    chk("abort_sample", sample_o, 0);
    repeat (5) step();
    mips_rst = 1'b1;
    hist.delete();
    step();
    chk("abort_no_pulse", valid_cnt - v0, 0);
    pulse_req();
    wait_valid("post_rst_wait", 300, cyc);
    chk("post_rst_latency", cyc, 131);
    repeat (3) step();
    check_rec("post_rst", 1'b1);

`ifdef SPI_ADC_AVG_EN
    // Moving average from a clean window
    mips_rst = 1'b0;
    step();
    mips_rst = 1'b1;
    step();
    hist.delete();
    avg_raw  = '{8'h40, 8'h80, 8'hC0, 8'hFF};
    avg_exp  = '{8'h10, 8'h30, 8'h60, 8'h9F};
    fixed_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fixed_word = 16'(avg_raw[i]) << DATA_LSB;
      pulse_req();
      wait_valid("avg_wait", 300, cyc);
      chk("avg_sample", sample_o, avg_exp[i]);
      repeat (3) step();
      check_rec("avg", 1'b1);
    end
    fixed_en = 1'b0;
`else
    avg_raw = '{8'h00, 8'h00, 8'h00, 8'h00};
    avg_exp = avg_raw;
`endif

    chk("records_drained", rec_frame.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
